seven_seg_scan_reader: RTL and testbench
========================================

Name: seven_seg_scan_reader

Overview:
- Receive-side counterpart of the hex-to-segment decode path. Monitors a time-multiplexed 7-segment display bus (one-hot digit enables plus shared segment lines) and recovers the 4-bit hex value of every digit.
- Publishes the recovered digits atomically once per complete scan frame.
- Used as a loopback checker on display outputs and to read external display modules.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (2..8).
- STABLE_CYCLES, 4, consecutive cycles an enable+segment combination must hold before it is captured (>=1).
- SEG_ACTIVE_LOW, 0, 1 = segment lines are active-low; inverted internally before decode.
- AN_ACTIVE_LOW, 0, 1 = digit enables are active-low; inverted internally.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- seg_in, input, 7, segment lines {a,b,c,d,e,f,g}; seg_in[6]=a.
- an_in, input, DIGITS, digit enables; bit i selects digit i.
- digits_out, output, 4*DIGITS, recovered values; digit i at [4i+3:4i].
- invalid_out, output, DIGITS, bit i=1: digit i's last pattern was not a legal hex glyph.
- frame_valid, output, 1, single-cycle pulse when digits_out/invalid_out update.
- scan_err, output, 1, single-cycle pulse when a stable non-one-hot, non-zero enable is detected.

Behaviour:
- Input stage: seg_in and an_in are registered once, with polarity normalised per the parameters. All logic below operates on the registered copies.
- Glyph table (normalised, hex, pattern -> value): 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->b, 4E->C, 3D->d, 4F->E, 47->F. Any other pattern decodes to value 0 and is flagged invalid.
- Stability counter:
  - Compares the registered {an,seg} with its previous-cycle value.
  - On any change, the counter clears to 0 and the captured flag clears.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
- FSM has two states, SETTLE and HELD.
  - SETTLE -> HELD when the counter reaches STABLE_CYCLES-1 with an unchanged combination.
  - HELD -> SETTLE on any input change.
  - Capture happens exactly once, on entry to HELD.
- Capture rules on entry to HELD:
  - an one-hot at bit i: shadow value[i] <= decoded nibble; shadow invalid[i] <= illegal glyph; seen[i] <= 1. Recapturing an already-seen digit overwrites its shadow value.
  - an == 0 (blanking): no action.
  - an non-zero and not one-hot: scan_err pulses for 1 cycle; no shadow update.
- Frame completion:
  - On the cycle after seen becomes all ones, digits_out <= shadow values, invalid_out <= shadow invalid, frame_valid pulses for 1 cycle, and seen clears to 0.
  - Outputs hold between frames.
- Latency: a combination presented at the pins for STABLE_CYCLES cycles is captured STABLE_CYCLES+1 cycles after first appearing. frame_valid follows the final digit's capture by 1 cycle.
- Simultaneous events: if a capture completes the seen mask and a new combination arrives on the same cycle, the capture and frame publish still occur, and the new combination starts a fresh stability count.
- Glitch rejection: combinations held fewer than STABLE_CYCLES cycles are never captured.
- Reset values:
  - digits_out = 0, invalid_out = 0, frame_valid = 0, scan_err = 0.
  - Shadow registers, seen mask, counter and input registers = 0.
  - FSM = SETTLE.
  - Reset mid-frame discards partial captures; no frame_valid is issued for the interrupted frame.

Test Plan:
- DIGITS=4, STABLE_CYCLES=4; scan an=0001/0010/0100/1000 with seg=7E,30,6D,79, each held 6 cycles -> one frame_valid pulse, digits_out=16'h3210, invalid_out=0.
- Same scan with digit 2 carrying seg=7F and digit 3 carrying 47, held 8 cycles each; repeat twice -> two frame_valid pulses, each with digits_out=16'hF810.
- Digit 1 held at seg=7F for 3 cycles, then 30 for 6 cycles -> captured value for digit 1 is 1, never 8.
- Digit 0 presents seg=00 (all off) within an otherwise valid frame -> frame_valid pulses, digits_out[3:0]=0, invalid_out=4'b0001.
- an=0011 held 6 cycles -> exactly one scan_err pulse, seen unchanged, no frame_valid. an=0000 held 6 cycles -> no pulses.
- Capture 3 of 4 digits, assert rst for 1 cycle, then scan all 4 with values 9,A,b,C (digits 0..3) -> single frame_valid with digits_out=16'hCBA9. SEG_ACTIVE_LOW=1 with inverted patterns gives identical results.

Source files
------------

// File: rtl/seven_seg_scan_reader.sv
// seven_seg_scan_reader
//   Watches a time-multiplexed 7-segment display bus and recovers the hex
//   value shown on every digit position. A digit is captured only after its
//   enable+segment combination has been steady long enough. Once every digit
//   has been seen, the whole set is published in one go.
//
// Ports
//   clk          rising-edge system clock
//   rst          synchronous active-high reset
//   seg_in       segment lines {a,b,c,d,e,f,g}, seg_in[6] = a
//   an_in        digit enables, bit i selects digit i
//   digits_out   recovered nibbles, digit i at [4i+3:4i]
//   invalid_out  bit i set when digit i's last pattern was not a hex glyph
//   frame_valid  one-cycle pulse when digits_out/invalid_out update
//   scan_err     one-cycle pulse when a steady multi-hot enable is captured
module seven_seg_scan_reader #(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     invalid_out,
  output logic                  frame_valid,
  output logic                  scan_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  // The counter lags the stable run by one sample, so HELD is entered on the
  // same edge that the counter steps up to STABLE_CYCLES-1.
  localparam int READY_AT = (STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0;

  typedef enum logic {SETTLE, HELD} state_t;

  state_t                state, state_next;
  logic [6:0]            seg_q, seg_p;
  logic [DIGITS-1:0]     an_q, an_p;
  logic [CW-1:0]         cnt;
  logic [4*DIGITS-1:0]   shadow_val;
  logic [DIGITS-1:0]     shadow_inv;
  logic [DIGITS-1:0]     seen;
  logic                  changed;
  logic                  ready;
  logic                  capture;
  logic                  one_hot;
  logic                  seen_full;
  logic [4:0]            dec;

  // Returns {illegal, value}; unknown patterns decode to 0 and are flagged.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pattern);
    logic [4:0] r;
    case (pattern)
      7'h7E:   r = 5'h00;
      7'h30:   r = 5'h01;
      7'h6D:   r = 5'h02;
      7'h79:   r = 5'h03;
      7'h33:   r = 5'h04;
      7'h5B:   r = 5'h05;
      7'h5F:   r = 5'h06;
      7'h70:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h7B:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h1F:   r = 5'h0B;
      7'h4E:   r = 5'h0C;
      7'h3D:   r = 5'h0D;
      7'h4F:   r = 5'h0E;
      7'h47:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign changed   = (an_q != an_p) || (seg_q != seg_p);
  assign ready     = (cnt >= CW'(READY_AT));
  assign one_hot   = (an_q != '0) && ((an_q & (an_q - DIGITS'(1))) == '0);
  assign seen_full = &seen;
  assign dec       = decode_glyph(seg_q);

  // Input stage, previous-sample copy, stability counter and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      an_q  <= '0;
      seg_p <= '0;
      an_p  <= '0;
      cnt   <= '0;
      state <= SETTLE;
    end else begin
      seg_q <= SEG_ACTIVE_LOW ? ~seg_in : seg_in;
      an_q  <= AN_ACTIVE_LOW  ? ~an_in  : an_in;
      seg_p <= seg_q;
      an_p  <= an_q;
      if (changed) begin
        cnt <= '0;
      end else if (cnt != CW'(STABLE_CYCLES)) begin
        cnt <= cnt + CW'(1);
      end
      state <= state_next;
    end
  end

  // Capture fires once, on the SETTLE->HELD transition.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      SETTLE: begin
        if (!changed && ready) begin
          state_next = HELD;
          capture    = 1'b1;
        end
      end
      HELD: begin
        if (changed) begin
          state_next = SETTLE;
        end
      end
      default: state_next = SETTLE;
    endcase
  end

  // Shadow registers, seen mask and frame publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val  <= '0;
      shadow_inv  <= '0;
      seen        <= '0;
      digits_out  <= '0;
      invalid_out <= '0;
      frame_valid <= 1'b0;
      scan_err    <= 1'b0;
    end else begin
      if (capture && one_hot) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (an_q[i]) begin
            shadow_val[4*i +: 4] <= dec[3:0];
            shadow_inv[i]        <= dec[4];
          end
        end
      end
      // A capture landing on the publish edge must survive the clear.
      seen <= (seen_full ? '0 : seen) | ((capture && one_hot) ? an_q : '0);
      scan_err    <= capture && (an_q != '0) && !one_hot;
      frame_valid <= seen_full;
      if (seen_full) begin
        digits_out  <= shadow_val;
        invalid_out <= shadow_inv;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Testbench for seven_seg_scan_reader: an active-high and an active-low
// instance are driven with the same logical stimulus and compared every
// cycle against a sample-based reference model.
module tb_seven_seg_scan_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam int MAXC   = 8192;

  typedef struct {
    logic [3:0][6:0] segs;
    logic [15:0]     expDigits;
    logic [3:0]      expInv;
  } frameVec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = '0;
  logic [3:0]  an  = '0;
  logic [6:0]  segL;
  logic [3:0]  anL;
  logic [15:0] digitsH, digitsL;
  logic [3:0]  invH, invL;
  logic        fvH, fvL, errH, errL;

  assign segL = ~seg;
  assign anL  = ~an;

  seven_seg_scan_reader #(
    .DIGITS(DIGITS), .STABLE_CYCLES(STABLE),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .seg_in(seg), .an_in(an),
    .digits_out(digitsH), .invalid_out(invH),
    .frame_valid(fvH), .scan_err(errH)
  );

  seven_seg_scan_reader #(
    .DIGITS(DIGITS), .STABLE_CYCLES(STABLE),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dutL (
    .clk(clk), .rst(rst), .seg_in(segL), .an_in(anL),
    .digits_out(digitsL), .invalid_out(invL),
    .frame_valid(fvL), .scan_err(errL)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cycle = 0;
  int fvCount = 0;
  int errCount = 0;

  bit          expFv  [MAXC];
  bit          expErr [MAXC];
  logic [15:0] expDig [MAXC];
  logic [3:0]  expInv [MAXC];

  logic [3:0]  mLastAn = '0;
  logic [6:0]  mLastSeg = '0;
  int          mRun = 0;
  logic [15:0] mVal = '0;
  logic [3:0]  mInv = '0;
  logic [3:0]  mSeen = '0;
  logic [15:0] pubDig = '0;
  logic [3:0]  pubInv = '0;
  bit          rstSeen = 1'b0;

  logic [6:0]  glyphs [16];
  frameVec_t   tbl [6];

  function automatic int glyphValue(input logic [6:0] s);
    case (s)
      7'h7E: return 0;   7'h30: return 1;   7'h6D: return 2;   7'h79: return 3;
      7'h33: return 4;   7'h5B: return 5;   7'h5F: return 6;   7'h70: return 7;
      7'h7F: return 8;   7'h7B: return 9;   7'h77: return 10;  7'h1F: return 11;
      7'h4E: return 12;  7'h3D: return 13;  7'h4F: return 14;  7'h47: return 15;
      default: return -1;
    endcase
  endfunction

  function automatic frameVec_t mkVec(input logic [6:0] s0, input logic [6:0] s1,
                                      input logic [6:0] s2, input logic [6:0] s3,
                                      input logic [15:0] d, input logic [3:0] inv);
    frameVec_t v;
    v.segs      = {s3, s2, s1, s0};
    v.expDigits = d;
    v.expInv    = inv;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
                  name, cycle, actual, expected);
  endtask

  // A combination sampled at STABLE consecutive edges is captured on the
  // following edge; scan_err shows after that edge, frame_valid one later.
  task automatic modelEdge();
    int n;
    int g;
    int idx;
    n = cycle;
    rstSeen = rst;
    if (rst) begin
      for (int k = n; k < n + 3; k++) begin
        expFv[k]  = 1'b0;
        expErr[k] = 1'b0;
      end
      mSeen = '0; mVal = '0; mInv = '0;
      mLastAn = '0; mLastSeg = '0;
      mRun = 2;
      return;
    end
    if (an == mLastAn && seg == mLastSeg) mRun++;
    else begin
      mRun = 1;
      mLastAn = an;
      mLastSeg = seg;
    end
    if (mRun != STABLE) return;
    if (an == 4'h0) return;
    if ($countones(an) != 1) begin
      expErr[n+1] = 1'b1;
      return;
    end
    idx = 0;
    for (int i = 0; i < DIGITS; i++) if (an[i]) idx = i;
    g = glyphValue(seg);
    mVal[4*idx +: 4] = (g < 0) ? 4'h0 : 4'(g);
    mInv[idx] = (g < 0);
    mSeen[idx] = 1'b1;
    if (mSeen == 4'hF) begin
      expFv[n+2]  = 1'b1;
      expDig[n+2] = mVal;
      expInv[n+2] = mInv;
      mSeen = '0;
    end
  endtask

  task automatic checkCycle();
    int n;
    n = cycle;
    if (rstSeen) begin
      pubDig = '0;
      pubInv = '0;
    end else if (expFv[n]) begin
      pubDig = expDig[n];
      pubInv = expInv[n];
    end
    checkOutput("frame_valid", fvH, expFv[n]);
    checkOutput("frame_valid_low", fvL, expFv[n]);
    checkOutput("scan_err", errH, expErr[n]);
    checkOutput("scan_err_low", errL, expErr[n]);
    checkOutput("digits_out", digitsH, pubDig);
    checkOutput("digits_out_low", digitsL, pubDig);
    checkOutput("invalid_out", invH, pubInv);
    checkOutput("invalid_out_low", invL, pubInv);
    if (fvH) fvCount++;
    if (errH) errCount++;
  endtask

  task automatic tick();
    @(posedge clk);
    cycle++;
    modelEdge();
    #1;
    checkCycle();
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int hold);
    an = a;
    seg = s;
    repeat (hold) tick();
  endtask

  task automatic scanFrame(input logic [3:0][6:0] segs, input int hold);
    for (int i = 0; i < DIGITS; i++) applyStimulus(4'(1 << i), segs[i], hold);
    applyStimulus(4'h0, 7'h00, 3);
  endtask

  initial begin
    int f0;
    int e0;
    logic [3:0] a;
    logic [6:0] s;

    glyphs = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    tbl[0] = mkVec(7'h7E, 7'h30, 7'h6D, 7'h79, 16'h3210, 4'b0000);
    tbl[1] = mkVec(7'h7E, 7'h30, 7'h7F, 7'h47, 16'hF810, 4'b0000);
    tbl[2] = mkVec(7'h77, 7'h1F, 7'h4E, 7'h3D, 16'hDCBA, 4'b0000);
    tbl[3] = mkVec(7'h00, 7'h30, 7'h6D, 7'h79, 16'h3210, 4'b0001);
    tbl[4] = mkVec(7'h4F, 7'h5B, 7'h5F, 7'h70, 16'h765E, 4'b0000);
    tbl[5] = mkVec(7'h7B, 7'h33, 7'h08, 7'h7F, 16'h8049, 4'b0100);

    rst = 1'b1;
    applyStimulus(4'h0, 7'h00, 3);
    checkOutput("reset_digits", digitsH, 16'h0000);
    checkOutput("reset_invalid", invH, 4'h0);
    rst = 1'b0;
    applyStimulus(4'h0, 7'h00, 2);

    // Table-driven full frames.
    for (int t = 0; t < 6; t++) begin
      f0 = fvCount;
      scanFrame(tbl[t].segs, 6);
      checkOutput("tbl_frame_count", 32'(fvCount - f0), 32'd1);
      checkOutput("tbl_digits", digitsH, tbl[t].expDigits);
      checkOutput("tbl_invalid", invH, tbl[t].expInv);
      checkOutput("tbl_digits_low", digitsL, tbl[t].expDigits);
      checkOutput("tbl_invalid_low", invL, tbl[t].expInv);
    end

    // Two consecutive long-hold frames.
    f0 = fvCount;
    scanFrame(tbl[1].segs, 8);
    scanFrame(tbl[1].segs, 8);
    checkOutput("repeat_frame_count", 32'(fvCount - f0), 32'd2);
    checkOutput("repeat_digits", digitsH, 16'hF810);

    // Short glitch on digit 1 must not be captured.
    applyStimulus(4'h1, 7'h7E, 6);
    applyStimulus(4'h2, 7'h7F, 3);
    applyStimulus(4'h2, 7'h30, 6);
    applyStimulus(4'h4, 7'h6D, 6);
    applyStimulus(4'h8, 7'h79, 6);
    applyStimulus(4'h0, 7'h00, 3);
    checkOutput("glitch_digit1", digitsH[7:4], 4'h1);

    // Multi-hot enable gives one scan_err; blanking gives nothing.
    f0 = fvCount;
    e0 = errCount;
    applyStimulus(4'b0011, 7'h30, 6);
    applyStimulus(4'h0, 7'h00, 3);
    checkOutput("multihot_err_count", 32'(errCount - e0), 32'd1);
    checkOutput("multihot_no_frame", 32'(fvCount - f0), 32'd0);
    e0 = errCount;
    applyStimulus(4'h0, 7'h7E, 6);
    applyStimulus(4'h0, 7'h00, 3);
    checkOutput("blank_err_count", 32'(errCount - e0), 32'd0);
    checkOutput("blank_no_frame", 32'(fvCount - f0), 32'd0);

    // Reset mid-frame discards partial captures.
    f0 = fvCount;
    applyStimulus(4'h1, 7'h7B, 6);
    applyStimulus(4'h2, 7'h77, 6);
    applyStimulus(4'h4, 7'h1F, 6);
    rst = 1'b1;
    applyStimulus(4'h0, 7'h00, 1);
    rst = 1'b0;
    checkOutput("midreset_digits", digitsH, 16'h0000);
    scanFrame(mkVec(7'h7B, 7'h77, 7'h1F, 7'h4E, 16'hCBA9, 4'h0).segs, 6);
    checkOutput("midreset_frame_count", 32'(fvCount - f0), 32'd1);
    checkOutput("midreset_digits_after", digitsH, 16'hCBA9);

    // Randomized scanning against the model.
    for (int r = 0; r < 400; r++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = 4'(1 << $urandom_range(0, 3));
        7:       a = 4'h0;
        default: a = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 7) == 0) s = 7'($urandom);
      else s = glyphs[$urandom_range(0, 15)];
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        applyStimulus(4'h0, 7'h00, 1);
        rst = 1'b0;
      end
      applyStimulus(a, s, $urandom_range(1, 7));
    end
    applyStimulus(4'h0, 7'h00, 4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
